// File: rtl/pipe_hazard_ctrl.sv
// Decode-stage hazard unit: tracks in-flight writers, selects forwarding paths, stalls on load-use.
// Optional mul/div issue blocking is compiled in when PIPE_HAZARD_MULDIV_EN is defined.
module pipe_hazard_ctrl #(
    parameter  int STAGES     = 3,
    parameter  int LOAD_STAGE = 2,
    parameter  int MULDIV_LAT = 4,
    localparam int FW         = $clog2(STAGES + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          id_valid,
    input  logic [4:0]    id_rs1,
    input  logic [4:0]    id_rs2,
    input  logic          id_rs1_used,
    input  logic          id_rs2_used,
    input  logic [4:0]    id_rd,
    input  logic          id_reg_write,
    input  logic          id_mem_read,
    input  logic          id_muldiv,
    input  logic          ex_redirect,
    output logic          stall,
    output logic          flush,
    output logic [FW-1:0] fwd_a,
    output logic [FW-1:0] fwd_b,
    output logic [15:0]   stall_cnt
);

    logic [STAGES:1]      vld_q, vld_d, rw_q, rw_d, mr_q, mr_d;
    logic [STAGES:1][4:0] rd_q, rd_d;
    logic [15:0]          stall_cnt_q, stall_cnt_d;
    logic                 a_ld, b_ld, busy, issue;

    // Scan oldest to youngest so the last hit wins: the smallest stage index.
    always_comb begin
        fwd_a = '0;
        fwd_b = '0;
        a_ld  = 1'b0;
        b_ld  = 1'b0;
        for (int k = STAGES; k >= 1; k--) begin
            if (id_rs1_used && id_rs1 != 5'd0 && vld_q[k] && rw_q[k] && rd_q[k] == id_rs1) begin
                fwd_a = FW'(k);
                a_ld  = mr_q[k] && (k < LOAD_STAGE);
            end
            if (id_rs2_used && id_rs2 != 5'd0 && vld_q[k] && rw_q[k] && rd_q[k] == id_rs2) begin
                fwd_b = FW'(k);
                b_ld  = mr_q[k] && (k < LOAD_STAGE);
            end
        end
    end

    // Redirect wins over every stall source; one stall covers load-use and mul/div together.
    assign stall = id_valid && !ex_redirect && (a_ld || b_ld || busy);
    assign flush = ex_redirect;
    assign issue = id_valid && !stall && !ex_redirect;

`ifdef PIPE_HAZARD_MULDIV_EN
    logic [3:0] md_cnt_q, md_cnt_d;

    assign busy = (md_cnt_q != 4'd0);

    always_comb begin
        md_cnt_d = md_cnt_q;
        if (issue && id_muldiv)
            md_cnt_d = 4'(MULDIV_LAT - 1);
        else if (busy)
            md_cnt_d = md_cnt_q - 4'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) md_cnt_q <= '0;
        else     md_cnt_q <= md_cnt_d;
    end
`else
    logic unused_muldiv;
    assign unused_muldiv = id_muldiv;
    assign busy          = 1'b0;
`endif

    always_comb begin
        vld_d[1] = issue;
        rd_d[1]  = id_rd;
        rw_d[1]  = id_reg_write;
        mr_d[1]  = id_mem_read;
        for (int k = 2; k <= STAGES; k++) begin
            vld_d[k] = vld_q[k-1];
            rd_d[k]  = rd_q[k-1];
            rw_d[k]  = rw_q[k-1];
            mr_d[k]  = mr_q[k-1];
        end
        stall_cnt_d = stall_cnt_q;
        if (stall && stall_cnt_q != 16'hFFFF)
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q       <= '0;
            rd_q        <= '0;
            rw_q        <= '0;
            mr_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            vld_q       <= vld_d;
            rd_q        <= rd_d;
            rw_q        <= rw_d;
            mr_q        <= mr_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule
